// File: rtl/rx_gate_ctrl.sv
// rtl/rx_gate_ctrl.sv - trigger-driven, rxstrobe-aligned capture gate for the RX buffer
module rx_gate_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TRIG_CNT_W  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  rxstrobe,
  input  logic                  enable,
  input  logic                  bypass,
  input  logic                  clear_status,
  input  logic [CNT_W-1:0]      delay,
  input  logic [CNT_W-1:0]      width,
  output logic                  gate_enable,
  output logic                  window_done,
  output logic                  missed_trigger,
  output logic [TRIG_CNT_W-1:0] trigger_count,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_WINDOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [TRIG_CNT_W-1:0] TRIG_ONE = 1;

  state_t                 st;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       width_reg;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   trig_pulse;

  // Trigger is asynchronous: synchronize first, then take the rising edge.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], trigger};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign state      = st;

  always_ff @(posedge rxclk) begin
    if (reset) begin
      st             <= S_IDLE;
      cnt            <= '0;
      width_reg      <= '0;
      gate_enable    <= 1'b0;
      window_done    <= 1'b0;
      missed_trigger <= 1'b0;
      trigger_count  <= '0;
    end else begin
      window_done <= 1'b0;
      // A trigger set later in this block wins over a same-cycle clear.
      if (clear_status) begin
        missed_trigger <= 1'b0;
      end
      if (bypass) begin
        st <= S_IDLE;
        if (rxstrobe) begin
          gate_enable <= enable;
        end
      end else begin
        case (st)
          S_IDLE: begin
            // Left over from bypass: close on a sample boundary only.
            if (rxstrobe) begin
              gate_enable <= 1'b0;
            end
            if (trig_pulse && enable && (width != '0)) begin
              cnt           <= delay;
              width_reg     <= width;
              trigger_count <= trigger_count + TRIG_ONE;
              st            <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (trig_pulse) begin
              missed_trigger <= 1'b1;
            end
            if (!enable) begin
              st <= S_IDLE;
            end else if (rxstrobe) begin
              if (cnt == '0) begin
                gate_enable <= 1'b1;
                cnt         <= width_reg - CNT_ONE;
                st          <= S_WINDOW;
              end else begin
                cnt <= cnt - CNT_ONE;
              end
            end
          end
          S_WINDOW: begin
            if (trig_pulse) begin
              missed_trigger <= 1'b1;
            end
            if (rxstrobe) begin
              if ((cnt == '0) || !enable) begin
                gate_enable <= 1'b0;
                window_done <= 1'b1;
                st          <= S_IDLE;
              end else begin
                cnt <= cnt - CNT_ONE;
              end
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_gate_ctrl.sv
// tb/tb_rx_gate_ctrl.sv - self-checking bench for rx_gate_ctrl
module tb_rx_gate_ctrl;

  localparam int S = 2;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        rxstrobe = 1'b0;
  logic        enable = 1'b0;
  logic        bypass = 1'b0;
  logic        clear_status = 1'b0;
  logic [15:0] delay = '0;
  logic [15:0] width = '0;
  logic        gate_enable;
  logic        window_done;
  logic        missed_trigger;
  logic [15:0] trigger_count;
  logic [1:0]  state;

  rx_gate_ctrl #(.CNT_W(16), .TRIG_CNT_W(16), .SYNC_STAGES(S)) dut (
    .rxclk(rxclk), .reset(reset), .trigger(trigger), .rxstrobe(rxstrobe),
    .enable(enable), .bypass(bypass), .clear_status(clear_status),
    .delay(delay), .width(width), .gate_enable(gate_enable),
    .window_done(window_done), .missed_trigger(missed_trigger),
    .trigger_count(trigger_count), .state(state)
  );

  always #5 rxclk = ~rxclk;

  int n_total = 0;
  int n_pass  = 0;
  int cycle   = 0;
  int ph      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, act, exp);
  endtask

  // Reference: windows described by strobe counts since acceptance.
  bit          m_hist[$];
  bit          m_busy, m_gate, m_done, m_missed;
  int          m_n, m_d, m_w;
  logic [15:0] m_count;

  function automatic void m_reset();
    m_hist = {};
    for (int i = 0; i < S + 1; i++) m_hist.push_back(1'b0);
    m_busy = 0; m_gate = 0; m_done = 0; m_missed = 0;
    m_n = 0; m_d = 0; m_w = 0; m_count = '0;
  endfunction

  function automatic int m_state();
    if (!m_busy) return 0;
    return (m_n <= m_d) ? 1 : 2;
  endfunction

  function automatic void m_step();
    bit pulse;
    pulse = m_hist[m_hist.size()-S] & ~m_hist[m_hist.size()-S-1];
    if (reset) begin
      m_reset();
      return;
    end
    m_hist.push_back(trigger);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    m_done = 0;
    if (clear_status) m_missed = 0;
    if (bypass) begin
      m_busy = 0;
      if (rxstrobe) m_gate = enable;
    end else if (!m_busy) begin
      if (rxstrobe) m_gate = 0;
      if (pulse && enable && width != 0) begin
        m_busy = 1; m_n = 0; m_d = int'(delay); m_w = int'(width);
        m_count = m_count + 16'd1;
      end
    end else begin
      if (pulse) m_missed = 1;
      if (m_n <= m_d) begin
        if (!enable) m_busy = 0;
        else if (rxstrobe) begin
          m_n++;
          if (m_n == m_d + 1) m_gate = 1;
        end
      end else if (rxstrobe) begin
        m_n++;
        if (m_n == m_d + m_w + 1 || !enable) begin
          m_gate = 0; m_done = 1; m_busy = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge rxclk);
    m_step();
    cycle++;
    #1;
    check("gate", int'(gate_enable), int'(m_gate));
    check("done", int'(window_done), int'(m_done));
    check("missed", int'(missed_trigger), int'(m_missed));
    check("count", int'(trigger_count), int'(m_count));
    check("state", int'(state), m_state());
  endtask

  int gate_cycles, done_cnt, delay_strobes;
  bit gate_seen, open_after_strobe;

  task automatic clr_stats();
    gate_cycles = 0; done_cnt = 0; delay_strobes = 0;
    gate_seen = 0; open_after_strobe = 0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      int pre_st;
      bit s;
      pre_st   = int'(state);
      rxstrobe = (ph % 8 == 0);
      s        = rxstrobe;
      ph++;
      tick();
      if (pre_st == 1 && s) delay_strobes++;
      if (gate_enable) gate_cycles++;
      if (window_done) done_cnt++;
      if (gate_enable && !gate_seen) begin
        gate_seen = 1;
        open_after_strobe = s;
      end
    end
    rxstrobe = 1'b0;
  endtask

  task automatic fire();
    trigger = 1'b1;
    observe(3);
    trigger = 1'b0;
  endtask

  task automatic wait_gate(input string name);
    int k;
    k = 0;
    while (!gate_enable && k < 200) begin
      observe(1);
      k++;
    end
    if (k >= 200) check({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    bit byp; bit en; bit stb; bit trg; bit exp_gate;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{1, 1, 0, 0, 0};
    vt[1] = '{1, 1, 1, 1, 1};
    vt[2] = '{1, 0, 0, 1, 1};
    vt[3] = '{1, 0, 0, 1, 1};
    vt[4] = '{1, 0, 1, 0, 0};
    vt[5] = '{1, 1, 0, 0, 0};
    vt[6] = '{1, 1, 1, 0, 1};
    vt[7] = '{0, 1, 0, 0, 1};
    vt[8] = '{0, 1, 1, 0, 0};

    m_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_gate", int'(gate_enable), 0);
    check("rst_state", int'(state), 0);
    check("rst_count", int'(trigger_count), 0);
    check("rst_missed", int'(missed_trigger), 0);
    enable = 1'b1;
    observe(5);

    // delay 3, width 5
    clr_stats(); delay = 16'd3; width = 16'd5;
    fire(); observe(90);
    check("t1_delay_strobes", delay_strobes, 4);
    check("t1_open_after_strobe", int'(open_after_strobe), 1);
    check("t1_gate_cycles", gate_cycles, 40);
    check("t1_done", done_cnt, 1);
    check("t1_count", int'(trigger_count), 1);
    check("t1_missed", int'(missed_trigger), 0);

    // delay 0, width 1
    clr_stats(); delay = 16'd0; width = 16'd1;
    fire(); observe(40);
    check("t2_delay_strobes", delay_strobes, 1);
    check("t2_gate_cycles", gate_cycles, 8);
    check("t2_done", done_cnt, 1);

    // second trigger inside the window
    clr_stats(); delay = 16'd2; width = 16'd10;
    fire(); observe(40);
    fire(); observe(80);
    check("t3_gate_cycles", gate_cycles, 80);
    check("t3_missed", int'(missed_trigger), 1);
    check("t3_count", int'(trigger_count), 3);
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    check("t3_cleared", int'(missed_trigger), 0);

    // width 0 rejected, then latched values survive input changes
    clr_stats(); width = 16'd0;
    fire(); observe(20);
    check("t4_count", int'(trigger_count), 3);
    check("t4_state", int'(state), 0);
    check("t4_gate_cycles", gate_cycles, 0);
    clr_stats(); delay = 16'd4; width = 16'd2;
    fire(); observe(10);
    delay = 16'd0; width = 16'd9;
    observe(80);
    check("t4_delay_strobes", delay_strobes, 5);
    check("t4_gate_cycles", gate_cycles, 16);
    check("t4_count2", int'(trigger_count), 4);

    // enable dropped in the 4th sample of a width-10 window
    clr_stats(); delay = 16'd1; width = 16'd10;
    fire(); wait_gate("t5");
    observe(27);
    enable = 1'b0;
    observe(12);
    check("t5_gate_cycles", gate_cycles, 32);
    check("t5_done", done_cnt, 1);
    check("t5_state", int'(state), 0);
    enable = 1'b1;

    // reset in the middle of a window
    clr_stats(); delay = 16'd0; width = 16'd5;
    fire(); wait_gate("t6");
    observe(3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_gate", int'(gate_enable), 0);
    check("t6_state", int'(state), 0);
    check("t6_count", int'(trigger_count), 0);

    // bypass vectors
    for (int i = 0; i < 9; i++) begin
      bypass = vt[i].byp; enable = vt[i].en;
      rxstrobe = vt[i].stb; trigger = vt[i].trg;
      tick();
      check($sformatf("byp_gate_%0d", i), int'(gate_enable), int'(vt[i].exp_gate));
      check($sformatf("byp_state_%0d", i), int'(state), 0);
    end
    rxstrobe = 1'b0; trigger = 1'b0;
    check("byp_count", int'(trigger_count), 0);
    check("byp_missed", int'(missed_trigger), 0);

    // randomized run against the reference
    begin
      int since;
      since = 0;
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(63) == 0) enable = ~enable;
        if ($urandom_range(11) == 0) trigger = ~trigger;
        if ($urandom_range(15) == 0) delay = 16'($urandom_range(3));
        if ($urandom_range(15) == 0) width = 16'($urandom_range(4));
        clear_status = ($urandom_range(39) == 0);
        reset = ($urandom_range(699) == 0);
        rxstrobe = (since >= 3) && ($urandom_range(3) == 0);
        since = rxstrobe ? 0 : since + 1;
        tick();
      end
      reset = 1'b0; clear_status = 1'b0; rxstrobe = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_gate_ctrl.md
Name: rx_gate_ctrl

Overview:
Generates the sample-aligned gate_enable consumed by the RX buffer stage from an external radar trigger (inter-pulse sync). After each accepted trigger it skips a programmable number of decimated samples (rxstrobe events), then opens the gate for exactly a programmable number of samples. The gate only changes on rxstrobe boundaries, so every capture contains complete channel sets. It sits in the rxclk domain between the trigger input pin/decimators and the RX buffer.

Parameters:
CNT_W, 16, width of delay/width counters (samples)
TRIG_CNT_W, 16, width of accepted-trigger counter
SYNC_STAGES, 2, synchronizer flops on trigger input (>=2)

Ports:
rxclk  input  1  DSP clock; all logic on posedge
reset  input  1  synchronous, active-high reset
trigger  input  1  asynchronous external trigger, rising-edge active
rxstrobe  input  1  one-cycle decimated-sample strobe (spacing >= channels+1 cycles)
enable  input  1  arms the gate generator
bypass  input  1  1 = gate follows enable (free-run), trigger ignored
clear_status  input  1  one-cycle rxclk-domain pulse, clears missed_trigger
delay  input  CNT_W  samples to skip after trigger; latched at trigger acceptance
width  input  CNT_W  samples in window; latched at trigger acceptance; 0 = trigger rejected
gate_enable  output  1  registered gate to RX buffer
window_done  output  1  one-cycle pulse when a window closes
missed_trigger  output  1  sticky: trigger arrived while not IDLE
trigger_count  output  TRIG_CNT_W  accepted triggers, wraps
state  output  2  debug: 0 IDLE, 1 DELAY, 2 WINDOW

Behaviour:
- Reset (synchronous): state IDLE, gate_enable 0, window_done 0, missed_trigger 0, trigger_count 0, counter 0, synchronizer flops 0. Reset mid-window drops gate_enable on the next edge, unaligned; acceptable because the buffer is reset by the same signal.
- Trigger path: SYNC_STAGES flops, then edge detect trig_pulse = sync_last & ~sync_prev. trig_pulse asserts SYNC_STAGES+1 cycles after the trigger input rises; one pulse per rising edge.
- IDLE: on trig_pulse & enable & ~bypass & width!=0: latch delay/width, cnt <= delay, trigger_count +1, go DELAY. width==0: no state change, not counted, not missed. An rxstrobe in the acceptance cycle is not counted toward the delay.
- DELAY: on rxstrobe: if cnt==0, gate_enable <= 1, cnt <= width_reg-1, go WINDOW; else cnt <= cnt-1. So exactly delay samples are skipped, and the strobe that opens the gate is captured (gate high in the cycle after the strobe, aligned with buffer phase 1). enable low: go IDLE immediately (gate already 0).
- WINDOW: on rxstrobe: if cnt==0 or enable==0, gate_enable <= 0, window_done <= 1 for one cycle, go IDLE; else cnt <= cnt-1. Result: exactly width samples captured (fewer on abort, always whole samples).
- gate_enable changes only on an rxstrobe cycle edge, or on reset.
- trig_pulse in DELAY or WINDOW, including the cycle the window closes: ignored, missed_trigger <= 1. clear_status clears it. A simultaneous set and clear leaves it set.
- bypass=1: state held IDLE, gate_enable <= enable on each rxstrobe, triggers neither counted nor flagged.
- Counter arithmetic: unsigned CNT_W. Maximum window is 2^CNT_W-1 samples. trigger_count wraps from all-ones to 0.

Test Plan:
- Strobe every 8 cycles, delay=3, width=5, one trigger -> 3 strobes skipped, gate_enable high for exactly 5 strobe periods (40 cycles), starting the cycle after the 4th strobe. window_done pulses once, trigger_count=1, missed_trigger=0.
- delay=0, width=1 -> gate opens after the first post-trigger strobe and closes after the next strobe. Exactly 1 sample gated.
- Second trigger during WINDOW of delay=2, width=10 -> missed_trigger=1, trigger_count stays 1, window length unchanged. Then clear_status pulse -> missed_trigger=0.
- width=0 trigger -> state stays 0, trigger_count unchanged, gate_enable 0. Change delay/width inputs mid-DELAY -> the current window uses the latched values.
- enable dropped in the 4th strobe period of a width=10 window -> gate closes at the next strobe edge, window_done pulses, state=0.
- bypass=1, enable toggled between strobes -> gate_enable follows enable only at strobe edges. reset asserted mid-WINDOW -> all outputs 0 the next cycle.
